// File: rtl/mul_div_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer: FSM states, op codes,
// Booth recoding actions and step-count helpers.
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    FINISH  = 2'd3
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M2   = 3'd3,
    BOOTH_M1   = 3'd4
  } booth_e;

  // Group is {Q[2k+1], Q[2k], Q[2k-1]}.
  function automatic booth_e booth_decode(input logic [2:0] group);
    booth_e code;
    case (group)
      3'b001, 3'b010: code = BOOTH_P1;
      3'b011:         code = BOOTH_P2;
      3'b100:         code = BOOTH_M2;
      3'b101, 3'b110: code = BOOTH_M1;
      default:        code = BOOTH_ZERO;
    endcase
    return code;
  endfunction

  function automatic int mul_steps(input int bits);
    return bits / 2;
  endfunction

  function automatic int div_steps(input int bits);
    return bits;
  endfunction

endpackage

// File: rtl/mul_div_sequencer_booth_r4_recode.sv
// Combinational radix-4 Booth recoder: one 3-bit group and the multiplicand in, one
// signed partial product out, two bits wider than M so that -2*M(-2^(BITS-1)) stays exact.
module booth_r4_recode
  import mul_div_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [2:0]      i_group,
  input  logic [BITS-1:0] i_m,
  output logic [BITS+1:0] o_pp
);

  logic [BITS+1:0] w_m_ext;
  logic [BITS+1:0] w_m2;

  assign w_m_ext = {{2{i_m[BITS-1]}}, i_m};
  assign w_m2    = {w_m_ext[BITS:0], 1'b0};

  always_comb begin
    o_pp = '0;
    case (booth_decode(i_group))
      BOOTH_P1: o_pp = w_m_ext;
      BOOTH_P2: o_pp = w_m2;
      BOOTH_M2: o_pp = -w_m2;
      BOOTH_M1: o_pp = -w_m_ext;
      default:  o_pp = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle signed multiply (radix-4 Booth, one group per clock) with registered HI/LO.
// Define MUL_DIV_SEQUENCER_DIV_EN to add the restoring signed divider selected by op=1.
module mul_div_sequencer
  import mul_div_pkg::*;
#(
  parameter int BITS = 32  // even, >= 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            op,
  input  logic [BITS-1:0] operand_a,
  input  logic [BITS-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] hi_out,
  output logic [BITS-1:0] lo_out,
  output logic            div_by_zero,
  output state_e          dbg_state
);

  localparam int SW        = $clog2(BITS);
  localparam int MUL_STEPS = mul_steps(BITS);

  // Handshake: start is a one-cycle request honoured only in IDLE; busy covers the
  // run states, and done pulses for exactly the one FINISH cycle with HI/LO already valid.
  state_e r_state;
  state_e w_state_next;
  logic   w_busy;
  logic   w_done;

  logic [BITS-1:0]   r_m;
  logic [BITS-1:0]   r_q;
  logic              r_qm1;
  logic [2*BITS-1:0] r_acc;
  logic [SW-1:0]     r_step;
  logic [BITS-1:0]   r_hi;
  logic [BITS-1:0]   r_lo;

  logic              w_is_div;
  logic              w_div_zero;
  logic              w_last_mul;
  logic              w_last_div;
  logic [BITS+1:0]   w_pp;
  logic [2*BITS-1:0] w_pp_ext;
  logic [2*BITS-1:0] w_mul_acc;

  assign w_last_mul = (r_step == SW'(MUL_STEPS - 1));

`ifdef MUL_DIV_SEQUENCER_DIV_EN
  localparam int DIV_STEPS = div_steps(BITS);

  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dbz;
  logic [BITS:0]   w_rem_sh;
  logic [BITS:0]   w_diff;
  logic            w_ge;
  logic [BITS-1:0] w_rem_next;
  logic [BITS-1:0] w_quo_next;
  logic [BITS-1:0] w_rem_res;
  logic [BITS-1:0] w_quo_res;

  assign w_is_div   = (op == OP_DIV);
  assign w_div_zero = w_is_div && (operand_b == '0);
  assign w_last_div = (r_step == SW'(DIV_STEPS - 1));

  // Remainder lives in acc[BITS-1:0]; r_q shifts the dividend out and the quotient in.
  assign w_rem_sh   = {r_acc[BITS-1:0], r_q[BITS-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_ge       = ~w_diff[BITS];
  assign w_rem_next = w_ge ? w_diff[BITS-1:0] : w_rem_sh[BITS-1:0];
  assign w_quo_next = {r_q[BITS-2:0], w_ge};
  assign w_quo_res  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_rem_res  = r_neg_r ? -w_rem_next : w_rem_next;
  assign div_by_zero = r_dbz;
`else
  logic w_unused_op;

  assign w_unused_op = op;
  assign w_is_div    = 1'b0;
  assign w_div_zero  = 1'b0;
  assign w_last_div  = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  booth_r4_recode #(
    .BITS(BITS)
  ) u_recode (
    .i_group({r_q[1:0], r_qm1}),
    .i_m    (r_m),
    .o_pp   (w_pp)
  );

  assign w_pp_ext  = {{(BITS-2){w_pp[BITS+1]}}, w_pp};
  assign w_mul_acc = r_acc + (w_pp_ext << {r_step, 1'b0});

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_div_zero)    w_state_next = FINISH;
          else if (w_is_div) w_state_next = DIV_RUN;
          else               w_state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        w_busy = 1'b1;
        if (w_last_mul) w_state_next = FINISH;
      end
      DIV_RUN: begin
        w_busy = 1'b1;
        if (w_last_div) w_state_next = FINISH;
      end
      FINISH: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // HI/LO are loaded on the edge that enters FINISH so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_m    <= '0;
      r_q    <= '0;
      r_qm1  <= 1'b0;
      r_acc  <= '0;
      r_step <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
`ifdef MUL_DIV_SEQUENCER_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_step <= '0;
            r_qm1  <= 1'b0;
            r_m    <= operand_a;
            r_q    <= operand_b;
`ifdef MUL_DIV_SEQUENCER_DIV_EN
            r_dbz <= w_div_zero;
            if (w_div_zero) begin
              r_hi <= operand_a;
              r_lo <= '1;
            end else if (w_is_div) begin
              r_m     <= operand_b[BITS-1] ? -operand_b : operand_b;
              r_q     <= operand_a[BITS-1] ? -operand_a : operand_a;
              r_neg_q <= operand_a[BITS-1] ^ operand_b[BITS-1];
              r_neg_r <= operand_a[BITS-1];
            end
`endif
          end
        end
        MUL_RUN: begin
          r_acc  <= w_mul_acc;
          r_q    <= {2'b00, r_q[BITS-1:2]};
          r_qm1  <= r_q[1];
          r_step <= r_step + 1'b1;
          if (w_last_mul) begin
            r_hi <= w_mul_acc[2*BITS-1:BITS];
            r_lo <= w_mul_acc[BITS-1:0];
          end
        end
`ifdef MUL_DIV_SEQUENCER_DIV_EN
        DIV_RUN: begin
          r_acc  <= {{BITS{1'b0}}, w_rem_next};
          r_q    <= w_quo_next;
          r_step <= r_step + 1'b1;
          if (w_last_div) begin
            r_hi <= w_rem_res;
            r_lo <= w_quo_res;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer (BITS=32): spec vector table, hand-written corner sequences
// and random operations checked against an arithmetic reference model.
module tb_mul_div_sequencer;
  import mul_div_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;
  state_e      dbg_state;

  int checks   = 0;
  int failures = 0;

  // Observations of the last run_op call.
  int          obs_done_cyc;
  int          obs_busy_cnt;
  int          obs_done_cnt;
  logic [31:0] cap_hi, cap_lo, end_hi, end_lo;
  logic        cap_dbz, c1_dbz;
  logic        pc_busy, pc_done, pc_dbz;
  logic [31:0] pc_hi, pc_lo;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  mul_div_sequencer #(.BITS(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic dbz, output int lat);
    longint sa, sb, p, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = sa * sb;
    hi  = p[63:32];
    lo  = p[31:0];
    dbz = 1'b0;
    lat = 17;
`ifdef MUL_DIV_SEQUENCER_DIV_EN
    if (o) begin
      if (b == 32'd0) begin
        hi  = a;
        lo  = 32'hFFFF_FFFF;
        dbz = 1'b1;
        lat = 1;
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        hi  = r[31:0];
        lo  = q[31:0];
        lat = 33;
      end
    end
`endif
  endfunction

  // Launch one op; watch 40 cycles. Cycle n is sampled #1 after the n-th edge following
  // the accepting edge. Optionally inject a stray start or a clr at given cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input int inj_cyc, input int clr_cyc);
    obs_done_cyc = 0;
    obs_busy_cnt = 0;
    obs_done_cnt = 0;
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    op        = o;
    start     = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 40; c++) begin
      if (busy) obs_busy_cnt++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) begin
          obs_done_cyc = c;
          cap_hi  = hi_out;
          cap_lo  = lo_out;
          cap_dbz = div_by_zero;
        end
      end
      if (c == 1) c1_dbz = div_by_zero;
      if (c == clr_cyc + 1) begin
        pc_busy = busy;
        pc_done = done;
        pc_hi   = hi_out;
        pc_lo   = lo_out;
        pc_dbz  = div_by_zero;
      end
      if (c == 40) begin
        end_hi = hi_out;
        end_lo = lo_out;
      end
      start = 1'b0;
      clr   = 1'b0;
      if (c == inj_cyc) begin
        operand_a = $urandom();
        operand_b = $urandom();
        op        = 1'b0;
        start     = 1'b1;
      end
      if (c == clr_cyc) clr = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input logic exp_dbz, input int exp_lat);
    check({name, ".latency"}, 64'(obs_done_cyc), 64'(exp_lat));
    check({name, ".done_pulses"}, 64'(obs_done_cnt), 64'd1);
    check({name, ".busy_cycles"}, 64'(obs_busy_cnt), 64'(exp_lat - 1));
    check({name, ".hi"}, 64'(cap_hi), 64'(exp_hi));
    check({name, ".lo"}, 64'(cap_lo), 64'(exp_lo));
    check({name, ".dbz"}, 64'(cap_dbz), 64'(exp_dbz));
    check({name, ".hold"}, {end_hi, end_lo}, {exp_hi, exp_lo});
  endtask

  task automatic model_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input int inj_cyc);
    logic [31:0] eh, el;
    logic        ed;
    int          lat;
    ref_op(a, b, o, eh, el, ed, lat);
    run_op(a, b, o, inj_cyc, 0);
    check_result(name, eh, el, ed, lat);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000;
      1:       v = 32'h0000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h0000_0001;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    clr       = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi_out), 64'd0);
    check("reset.lo", 64'(lo_out), 64'd0);
    check("reset.dbz", 64'(div_by_zero), 64'd0);
    check("reset.state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    clr = 1'b0;

    vecs.push_back('{"mul_7x-3", 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 17});
    vecs.push_back('{"mul_min_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, 1'b0, 17});
    vecs.push_back('{"mul_min_1", 32'h8000_0000, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 17});
    vecs.push_back('{"mul_max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h1, 1'b0, 17});
    vecs.push_back('{"mul_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1, 1'b0, 17});
    vecs.push_back('{"mul_zero", 32'h0, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, 17});
`ifdef MUL_DIV_SEQUENCER_DIV_EN
    vecs.push_back('{"div_-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{"div_100/0", 32'd100, 32'd0, 1'b1, 32'h64, 32'hFFFF_FFFF, 1'b1, 1});
    vecs.push_back('{"div_7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h1, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{"div_min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{"div_1000/7", 32'd1000, 32'd7, 1'b1, 32'd6, 32'd142, 1'b0, 33});
`else
    vecs.push_back('{"op1_is_mul", 32'd7, 32'd6, 1'b1, 32'h0, 32'd42, 1'b0, 17});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].o, 0, 0);
      check_result(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz, vecs[i].exp_lat);
    end

    // Stray starts while running and while in FINISH must be ignored.
    model_op("ignored_start_run", 32'd12345, 32'hFFFF_0F0F, 1'b0, 5);
    model_op("ignored_start_finish", 32'h8000_0000, 32'd3, 1'b0, 17);

    // clr in cycle 8 aborts: outputs cleared next cycle, no done.
    run_op(32'h0000_BEEF, 32'h0000_0123, 1'b0, 0, 8);
    check("abort.done_pulses", 64'(obs_done_cnt), 64'd0);
    check("abort.busy", 64'(pc_busy), 64'd0);
    check("abort.done", 64'(pc_done), 64'd0);
    check("abort.hi", 64'(pc_hi), 64'd0);
    check("abort.lo", 64'(pc_lo), 64'd0);
    check("abort.dbz", 64'(pc_dbz), 64'd0);
    model_op("after_abort", 32'hFFFF_FF00, 32'd77, 1'b0, 0);

`ifdef MUL_DIV_SEQUENCER_DIV_EN
    // Flag set by divide-by-zero drops on the next accepted start.
    model_op("dbz_set", 32'd100, 32'd0, 1'b1, 0);
    model_op("dbz_clear", 32'd9, 32'd3, 1'b0, 0);
    check("dbz_clear.cycle1", 64'(c1_dbz), 64'd0);
`endif

    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra, rb;
      logic        ro;
      ra = pick_operand();
      rb = pick_operand();
`ifdef MUL_DIV_SEQUENCER_DIV_EN
      ro = 1'($urandom_range(0, 1));
`else
      ro = 1'b0;
`endif
      model_op($sformatf("rand%0d", n), ra, rb, ro, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Multi-cycle multiply/divide unit for the bus-architecture datapath.
- Multiply: signed radix-4 Booth, one 3-bit recoding group per clock (BITS/2 steps).
- Result lands in registered HI/LO outputs, which the control unit transfers onto the bus after done.
- Replaces the single-cycle combinational multiply path, which cannot close timing at the target clock.

Parameters:
- BITS, 32, operand width; must be even and >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches an operation when idle.
- op  in  1  0 = signed multiply, 1 = signed divide (divide only with DIV_EN).
- operand_a  in  BITS  multiplicand / dividend; sampled on the accepted start.
- operand_b  in  BITS  multiplier / divisor; sampled on the accepted start.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- hi_out  out  BITS  product[2*BITS-1:BITS] / remainder.
- lo_out  out  BITS  product[BITS-1:0] / quotient.
- div_by_zero  out  1  high with done when divisor == 0; held until next accepted start.

Behaviour:
- Reset (clr=1 at a rising edge):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0; internal accumulator and step counter cleared.
  - clr has priority over every other input.
  - clr mid-operation aborts the operation; no done is produced.
- States: IDLE, MUL_RUN, DIV_RUN, FINISH.
- IDLE:
  - start=1 latches operand_a and operand_b, clears the accumulator, and sets step=0.
  - Next state is MUL_RUN (op=0) or DIV_RUN (op=1 with DIV_EN).
  - hi_out and lo_out keep the previous result.
- start while busy or in FINISH is ignored; latched operands are unaffected.
- MUL_RUN:
  - Step k (0..BITS/2-1) forms group {Q[2k+1], Q[2k], Q[2k-1]}, with Q[-1]=0.
  - Recoding: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Partial product is formed at BITS+2 bits so M = -2^(BITS-1) is exact, then sign-extended to 2*BITS.
  - acc <= acc + (pp << 2k), modulo 2^(2*BITS).
  - After step BITS/2-1, go to FINISH.
- FINISH (one cycle):
  - hi_out/lo_out are loaded from acc (registered); done=1, busy=0; return to IDLE.
- Latency: start accepted at edge 0 -> done high in cycle BITS/2+1 (17 at BITS=32).
- busy is high for BITS/2 cycles.
- Outputs hold until the next FINISH or clr.

Optional Feature:
- Macro: MUL_DIV_SEQUENCER_DIV_EN.
- With the macro defined, op=1 selects DIV_RUN:
  - Restoring division on magnitudes, one quotient bit per cycle, BITS cycles.
  - Quotient is truncated toward zero; remainder takes the sign of the dividend.
  - lo_out = quotient; hi_out = remainder.
  - Latency: done in cycle BITS+1.
  - Divisor == 0: skip DIV_RUN; FINISH on the next cycle (done in cycle 1) with lo_out = all ones, hi_out = dividend, div_by_zero = 1.
  - Overflow case -2^(BITS-1) / -1: lo_out = -2^(BITS-1), hi_out = 0, no flag.
- Without the macro:
  - op is ignored and every start is a multiply.
  - div_by_zero is tied 0.
  - No divider logic is synthesized.

Decomposition:
- Package mul_div_pkg holds:
  - state enum (IDLE, MUL_RUN, DIV_RUN, FINISH);
  - op encodings (OP_MUL=0, OP_DIV=1);
  - Booth group codes;
  - step-count constants MUL_STEPS = BITS/2 and DIV_STEPS = BITS.
- One sub-module: booth_r4_recode, combinational. Takes a 3-bit group and M; returns the BITS+2-bit signed partial product. The sequencer instantiates it once.

Test Plan (BITS=32):
- Multiply 7 x -3: start with a=7, b=0xFFFFFFFD -> done in cycle 17; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-16.
- Most-negative operands: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Then a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Ignored start: start pulse in cycle 5 of a running multiply with new operands -> the first result is unchanged and exactly one done pulse is produced.
- Reset mid-operation: clr in cycle 8 -> all outputs 0 the next cycle, no done; a fresh start afterwards completes normally.
- (DIV_EN) Divide -7 / 2: done in cycle 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
- (DIV_EN) Divide by zero, 100 / 0: done in cycle 1; lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1, cleared on the next accepted start.
